// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract, split into STAGES carry-chain chunks with a valid/ready handshake.
// Optional signed saturation is compiled in when PIPELINED_ADDSUB_SAT_EN is defined.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // The whole pipeline moves as one unit; only a held output stalls it.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int RW = WIDTH - k * CW;  // operand bits from this chunk upward

    logic [RW-1:0]       src_a;
    logic [RW-1:0]       src_b;
    logic                src_c;
    logic                src_v;
    logic [CW:0]         chunk;
    logic [(k+1)*CW-1:0] sum_next;
    logic [(k+1)*CW-1:0] s_q;
    logic                c_q;
    logic                v_q;
`ifdef PIPELINED_ADDSUB_SAT_EN
    logic                src_sat;
    logic                sat_q;
`endif

    assign chunk = {1'b0, src_a[CW-1:0]} + {1'b0, src_b[CW-1:0]} + {{CW{1'b0}}, src_c};

    if (k == 0) begin : g_first
      assign src_a    = a;
      assign src_b    = b ^ {WIDTH{sub}};
      assign src_c    = sub;
      assign src_v    = in_valid;
      assign sum_next = chunk[CW-1:0];
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign src_sat  = sat;
`endif
    end else begin : g_next
      assign src_a    = g_stage[k-1].g_skew.a_q;
      assign src_b    = g_stage[k-1].g_skew.b_q;
      assign src_c    = g_stage[k-1].c_q;
      assign src_v    = g_stage[k-1].v_q;
      assign sum_next = {chunk[CW-1:0], g_stage[k-1].s_q};
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign src_sat  = g_stage[k-1].sat_q;
`endif
    end

    // NOTE: datapath registers are reset as well, so the result fields read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= src_v;
        c_q <= chunk[CW];
        s_q <= sum_next;
      end
    end

`ifdef PIPELINED_ADDSUB_SAT_EN
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)     sat_q <= 1'b0;
      else if (adv) sat_q <= src_sat;
    end
`endif

    if (k < LAST) begin : g_skew
      logic [RW-CW-1:0] a_q;
      logic [RW-CW-1:0] b_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= src_a[RW-1:CW];
          b_q <= src_b[RW-1:CW];
        end
      end
    end else begin : g_msb
      logic cmsb_q;  // carry into the result MSB
`ifdef PIPELINED_ADDSUB_SAT_EN
      logic a_msb_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)     a_msb_q <= 1'b0;
        else if (adv) a_msb_q <= src_a[CW-1];
      end
`endif

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)     cmsb_q <= 1'b0;
        else if (adv) cmsb_q <= src_a[CW-1] ^ src_b[CW-1] ^ chunk[CW-1];
      end
    end
  end

  logic [WIDTH-1:0] wrapped;
  assign wrapped   = g_stage[LAST].s_q;
  assign out_valid = g_stage[LAST].v_q;
  assign c_out     = g_stage[LAST].c_q;
  assign ovf       = g_stage[LAST].g_msb.cmsb_q ^ g_stage[LAST].c_q;

`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;

  // NOTE: result gets its default first so this block can never infer a latch.
  always_comb begin
    result = wrapped;
    if (g_stage[LAST].sat_q && ovf)
      result = g_stage[LAST].g_msb.a_msb_q ? SMIN : SMAX;
  end
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign result     = wrapped;
`endif

  // Gated by out_valid so an empty pipeline does not report a zero result.
  assign zero = out_valid && (result == '0);

endmodule
